// File: rtl/axi_lite_master_bridge.sv
// Bridges a single-outstanding command/response port onto an AXI-Lite master.
// A response wait may time out; the late response is then drained before new commands.
module axi_lite_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "axi_lite_master_bridge: DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    is_write_q, is_write_d;
    logic                    drain_q, drain_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            is_write_q    <= 1'b0;
            drain_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cnt_q         <= '0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            is_write_q    <= is_write_d;
            drain_q       <= drain_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cnt_q         <= cnt_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        is_write_d    = is_write_q;
        drain_d       = drain_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        cnt_d         = cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        timeout_hit   = TIMEOUT_EN && (cnt_q >= CNT_LIMIT);

        if ((state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    wstrb_d    = cmd_wstrb;
                    cnt_d      = '0;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    is_write_d = cmd_write;
                    state_d    = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // ready only matters while the matching valid is still up
                aw_done_d = aw_done_q | m_axi_awready;
                w_done_d  = w_done_q | m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    rsp_resp_d    = m_axi_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (timeout_hit) begin
                    rsp_resp_d    = 2'b10;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    drain_d       = 1'b1;
                    state_d       = RSP;
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid) begin
                    rsp_resp_d    = m_axi_rresp;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (timeout_hit) begin
                    rsp_resp_d    = 2'b10;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    drain_d       = 1'b1;
                    state_d       = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = drain_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (is_write_q ? m_axi_bvalid : m_axi_rvalid) begin
                    drain_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = (state_q == WR_RESP) || ((state_q == DRAIN) && is_write_q);
    assign m_axi_arvalid = (state_q == RD_REQ);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = (state_q == RD_RESP) || ((state_q == DRAIN) && !is_write_q);
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: register-file slave plus a transaction-level
// reference model that is compared against the bridge every cycle.
module tb_axi_lite_master_bridge;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_axi_awvalid, m_axi_awready = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_wvalid, m_axi_wready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid = 1'b0, m_axi_bready;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_arvalid, m_axi_arready = 1'b0;
    logic [31:0] m_axi_araddr;
    logic        m_axi_rvalid = 1'b0, m_axi_rready;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;

    always #5 clk = ~clk;

    axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Slave configuration set by the stimulus
    int   aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic b_block = 1'b0;

    // Slave state
    logic [31:0] slv_mem [0:63] = '{default: 32'h0};
    logic        s_have_aw = 0, s_have_w = 0, b_pend = 0, r_pend = 0;
    logic [31:0] s_awaddr = 0, s_wdata = 0;
    logic [3:0]  s_wstrb = 0;
    logic [1:0]  b_resp_s = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;

    // Reference model state
    typedef struct {logic [31:0] rdata; logic [1:0] resp; logic to;} exp_t;
    exp_t        exp_q[$];
    logic [31:0] model_mem [0:63] = '{default: 32'h0};
    logic        busy = 0, cur_wr = 0, aw_seen = 0, w_seen = 0, ar_seen = 0;
    logic        drain_pend = 0, resp_seen = 0, rst_prev = 0;
    logic [31:0] cur_addr = 0, cur_data = 0;
    logic [3:0]  cur_strb = 0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic        p_rspv = 0, p_rspr = 0, p_to = 0;
    logic [31:0] p_rdata = 0;
    logic [1:0]  p_resp = 0;
    logic [31:0] last_rdata = 0;
    logic [1:0]  last_resp = 0;
    logic        last_to = 0;
    int cyc = 0, acc_cyc = 0, aw_first = -1, w_first = -1, ar_first = -1;
    int aw_hs_cyc = -1, w_hs_cyc = -1, ar_hs_cyc = -1, b_hs_cyc = -1, r_hs_cyc = -1;
    int rsp_first = -1, rsp_hs_cyc = -1, rsp_cnt = 0, b_cnt = 0, drain_cnt = 0;
    logic b_hs, r_hs, aw_hs, w_hs, ar_hs, rsp_hs, acc;
    exp_t e_cur;

    // Everything sampled mid-cycle: DUT outputs are settled, slave inputs set here for this cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst_prev) begin
            chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
            chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
        end
        if (reset) begin
            rst_prev = 1; busy = 0; drain_pend = 0; exp_q.delete();
            s_have_aw = 0; s_have_w = 0; b_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_rspv = 0;
        end else begin
            rst_prev = 0;
            m_axi_bvalid  = b_pend && !b_block;
            m_axi_bresp   = b_resp_s;
            b_hs          = m_axi_bvalid && m_axi_bready;
            m_axi_rvalid  = r_pend;
            r_hs          = m_axi_rvalid && m_axi_rready;
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            m_axi_wready  = m_axi_wvalid && (w_wait >= w_delay);
            m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            ar_hs = m_axi_arvalid && m_axi_arready;
            aw_wait = (m_axi_awvalid && !aw_hs) ? aw_wait + 1 : 0;
            w_wait  = (m_axi_wvalid && !w_hs) ? w_wait + 1 : 0;
            ar_wait = (m_axi_arvalid && !ar_hs) ? ar_wait + 1 : 0;
            rsp_hs = rsp_valid && rsp_ready;
            acc    = cmd_valid && cmd_ready;

            chk("cmd_ready", cmd_ready, !busy);
            chk("prot", {m_axi_awprot, m_axi_arprot}, 0);
            if (!busy) chk("rsp_valid_idle", rsp_valid, 0);
            if (rsp_valid)
                chk("rsp_axi_quiet", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
            if (m_axi_awvalid) begin
                chk("awvalid_legal", busy && cur_wr && !aw_seen && !drain_pend, 1);
                chk("awaddr", m_axi_awaddr, cur_addr);
            end
            if (m_axi_wvalid) begin
                chk("wvalid_legal", busy && cur_wr && !w_seen && !drain_pend, 1);
                chk("wdata_wstrb", {m_axi_wdata, m_axi_wstrb}, {cur_data, cur_strb});
            end
            if (m_axi_arvalid) begin
                chk("arvalid_legal", busy && !cur_wr && !ar_seen && !drain_pend, 1);
                chk("araddr", m_axi_araddr, cur_addr);
            end
            if (m_axi_bready) chk("bready_legal", busy && cur_wr && aw_seen && w_seen, 1);
            if (m_axi_rready) chk("rready_legal", busy && !cur_wr && ar_seen, 1);
            if (p_awv && !p_awr) chk("aw_hold", m_axi_awvalid, 1);
            if (p_wv && !p_wr)   chk("w_hold", m_axi_wvalid, 1);
            if (p_arv && !p_arr) chk("ar_hold", m_axi_arvalid, 1);
            if (p_rspv && !p_rspr) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_payload", {rsp_rdata, rsp_resp, rsp_timeout}, {p_rdata, p_resp, p_to});
            end
            if (m_axi_awvalid && aw_first < 0) aw_first = cyc;
            if (m_axi_wvalid && w_first < 0)   w_first = cyc;
            if (m_axi_arvalid && ar_first < 0) ar_first = cyc;
            if (rsp_valid && rsp_first < 0)    rsp_first = cyc;

            // model and slave updates take effect at the coming edge
            if (b_hs) begin
                b_pend = 0;
                if (drain_pend) begin
                    drain_pend = 0; busy = 0; drain_cnt++;
                end else begin
                    b_cnt++; resp_seen = 1; b_hs_cyc = cyc;
                end
            end
            if (r_hs) begin
                r_pend = 0;
                if (drain_pend) begin
                    drain_pend = 0; busy = 0; drain_cnt++;
                end else begin
                    resp_seen = 1; r_hs_cyc = cyc;
                end
            end
            if (aw_hs) begin aw_seen = 1; aw_hs_cyc = cyc; s_have_aw = 1; s_awaddr = m_axi_awaddr; end
            if (w_hs)  begin w_seen = 1; w_hs_cyc = cyc; s_have_w = 1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; end
            if (s_have_aw && s_have_w) begin
                if (s_awaddr < 32'h100) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) slv_mem[s_awaddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    b_resp_s = 2'b00;
                end else begin
                    b_resp_s = 2'b10;
                end
                b_pend = 1; s_have_aw = 0; s_have_w = 0;
            end
            if (ar_hs) begin
                ar_seen = 1; ar_hs_cyc = cyc; r_pend = 1;
                m_axi_rdata = (m_axi_araddr < 32'h100) ? slv_mem[m_axi_araddr[7:2]] : 32'h0;
                m_axi_rresp = (m_axi_araddr < 32'h100) ? 2'b00 : 2'b10;
            end
            if (rsp_hs) begin
                chk("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_cur = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e_cur.rdata);
                    chk("rsp_resp", rsp_resp, e_cur.resp);
                    chk("rsp_timeout", rsp_timeout, e_cur.to);
                    if (!e_cur.to) chk("rsp_after_axi", resp_seen, 1);
                    if (e_cur.to) drain_pend = 1; else busy = 0;
                end
                last_rdata = rsp_rdata; last_resp = rsp_resp; last_to = rsp_timeout;
                rsp_cnt++; rsp_hs_cyc = cyc;
            end
            if (acc) begin
                busy = 1; cur_wr = cmd_write; cur_addr = cmd_addr; cur_data = cmd_wdata; cur_strb = cmd_wstrb;
                aw_seen = 0; w_seen = 0; ar_seen = 0; resp_seen = 0; acc_cyc = cyc; b_cnt = 0;
                aw_first = -1; w_first = -1; ar_first = -1; rsp_first = -1;
                aw_hs_cyc = -1; w_hs_cyc = -1; ar_hs_cyc = -1; b_hs_cyc = -1; r_hs_cyc = -1;
            end
            p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_wv = m_axi_wvalid; p_wr = m_axi_wready;
            p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_rspv = rsp_valid; p_rspr = rsp_ready;
            p_rdata = rsp_rdata; p_resp = rsp_resp; p_to = rsp_timeout;
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic to);
        exp_t e;
        int   n = 0;
        logic mapped;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        mapped = (addr < 32'h100);
        e.rdata = 32'h0;
        e.resp  = mapped ? 2'b00 : 2'b10;
        if (wr && mapped) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
        end else if (!wr && mapped) begin
            e.rdata = model_mem[addr[7:2]];
        end
        if (to) begin e.rdata = 32'h0; e.resp = 2'b10; end
        e.to = to;
        exp_q.push_back(e);
        $display("[TB] cmd %s addr=%08h data=%08h strb=%h timeout_expected=%0d",
                 wr ? "WR" : "RD", addr, data, strb, to);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int limit);
        int start = rsp_cnt;
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (rsp_cnt == start && n < limit);
        chk("rsp_wait", rsp_cnt != start, 1);
        $display("[TB] rsp rdata=%08h resp=%0b timeout=%0d", last_rdata, last_resp, last_to);
    endtask

    initial begin
        int prev, n, start;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(posedge clk); #1;

        // zero-wait write
        issue(1, 32'h4, 32'hDEADBEEF, 4'hF, 0);
        wait_rsp(50);
        chk("wr_awvalid_cycle", aw_first - acc_cyc, 1);
        chk("wr_wvalid_cycle", w_first - acc_cyc, 1);
        chk("wr_aw_hs_cycle", aw_hs_cyc - acc_cyc, 1);
        chk("wr_b_hs_cycle", b_hs_cyc - acc_cyc, 2);
        chk("wr_rsp_cycle", rsp_first - acc_cyc, 3);
        chk("wr_resp", {last_resp, last_to}, 3'b000);

        // back-to-back read of the same word
        prev = rsp_hs_cyc;
        issue(0, 32'h4, 32'h0, 4'h0, 0);
        wait_rsp(50);
        chk("b2b_accept", acc_cyc - prev, 1);
        chk("rd_arvalid_cycle", ar_first - acc_cyc, 1);
        chk("rd_r_hs_cycle", r_hs_cyc - acc_cyc, 2);
        chk("rd_rsp_cycle", rsp_first - acc_cyc, 3);
        chk("rd_rdata", last_rdata, 32'hDEADBEEF);
        chk("rd_resp", last_resp, 2'b00);

        // unmapped read
        issue(0, 32'h100, 32'h0, 4'h0, 0);
        wait_rsp(50);
        chk("rd_unmapped_resp", last_resp, 2'b10);

        // AW stalled three cycles, W immediate
        aw_delay = 3;
        issue(1, 32'h8, 32'hA5A50001, 4'hF, 0);
        wait_rsp(50);
        chk("awstall_aw_hs", aw_hs_cyc - acc_cyc, 4);
        chk("awstall_w_hs", w_hs_cyc - acc_cyc, 1);
        chk("awstall_b_count", b_cnt, 1);
        chk("awstall_resp", last_resp, 2'b00);
        aw_delay = 0;

        // B never arrives: timeout, then late response drained
        b_block = 1;
        issue(1, 32'hC, 32'h11, 4'hF, 1);
        wait_rsp(60);
        chk("to_rsp_cycle", rsp_first - acc_cyc, TO + 2);
        chk("to_flag", last_to, 1);
        chk("to_resp", last_resp, 2'b10);
        chk("to_rdata", last_rdata, 0);
        repeat (40) begin @(posedge clk); #1; end
        chk("to_cmd_ready_blocked", cmd_ready, 0);
        b_block = 0;
        n = 0;
        while (!cmd_ready && n < 10) begin @(posedge clk); #1; n++; end
        chk("to_drain_idle", cmd_ready, 1);
        chk("to_drain_count", drain_cnt, 1);

        // response held by the consumer
        rsp_ready = 0;
        issue(0, 32'h4, 32'h0, 4'h0, 0);
        n = 0;
        while (!rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
        repeat (10) begin @(posedge clk); #1; end
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("hold_cmd_ready", cmd_ready, 0);
        rsp_ready = 1;
        wait_rsp(10);

        // reset while AW is pending
        aw_delay = 6;
        issue(1, 32'h20, 32'h55, 4'hF, 0);
        @(posedge clk); #1;
        chk("pre_reset_awvalid", m_axi_awvalid, 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("post_reset_awvalid", m_axi_awvalid, 0);
        @(posedge clk); #1;
        chk("post_reset_cmd_ready", cmd_ready, 1);
        aw_delay = 0;

        // partial strobes
        issue(1, 32'h10, 32'h12345678, 4'b0011, 0);
        wait_rsp(50);
        issue(0, 32'h10, 32'h0, 4'h0, 0);
        wait_rsp(50);
        chk("strb_rdata", last_rdata, 32'h00005678);
        chk("queue_empty", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
- Converts a simple single-transaction command/response interface into AXI-Lite master transactions.
- Sits between internal control logic (sequencers, debug ports) and AXI-Lite slaves such as the team's register-block slaves.
- One transaction outstanding at a time.
- Independent AW/W handshake tracking; optional response timeout with drain of late responses.

Parameters:
- ADDR_WIDTH, 32, address width of command and AXI address channels.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8. Only 32 or 64 are legal; any other value triggers $fatal at elaboration.
- TIMEOUT_CYCLES, 1024, response-wait timeout in cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid && ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid && ready
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
- rsp_resp  out  2  AXI response code (SLVERR 2'b10 on timeout)
- rsp_timeout  out  1  1 = transaction timed out
- m_axi_awvalid/awready/awaddr[ADDR_WIDTH]/awprot[3]  out/in/out/out  AW channel
- m_axi_wvalid/wready/wdata[DATA_WIDTH]/wstrb[DATA_WIDTH/8]  out/in/out/out  W channel
- m_axi_bvalid/bready/bresp[2]  in/out/in  B channel
- m_axi_arvalid/arready/araddr[ADDR_WIDTH]/arprot[3]  out/in/out/out  AR channel
- m_axi_rvalid/rready/rdata[DATA_WIDTH]/rresp[2]  in/out/in/in  R channel

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN. All valid/ready outputs are decoded from registered state and flags; there are no combinational in-to-out paths.
- Reset (any cycle, including mid-transaction): state is IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_timeout are 0; rsp_rdata and rsp_resp are 0; timeout counter is 0. In-flight transaction is abandoned.
- IDLE: cmd_ready=1 only here. On accept, latch addr, wdata, wstrb and clear the timeout counter. cmd_write=1 goes to WR_REQ; otherwise RD_REQ.
- WR_REQ: awvalid=!aw_done and wvalid=!w_done; both assert the cycle after accept.
  - Each flag sets on its own handshake.
  - awaddr, wdata, wstrb are stable while the corresponding valid is high.
  - A valid never drops before its handshake.
  - Leave for WR_RESP the cycle both flags are set, including when both handshakes occur in the same cycle.
- WR_RESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_rdata=0, and go to RSP.
- RD_REQ: arvalid=1 until arready, then RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and rresp, then go to RSP.
- awprot and arprot are constant 3'b000.
- Timeout:
  - Counter increments every cycle outside IDLE/RSP/DRAIN and saturates.
  - Checked only in WR_RESP/RD_RESP. Address/data valids are never withdrawn, per AXI rules.
  - If TIMEOUT_CYCLES!=0 and counter >= TIMEOUT_CYCLES while no response handshake is occurring this cycle, go to RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, and a pending-drain flag set.
  - A response arriving in the same cycle as expiry wins; it is normal completion.
- RSP: rsp_valid=1; payload is stable until rsp_ready. On handshake, go to DRAIN if the drain flag is set, else IDLE.
- DRAIN: hold bready (write) or rready (read) high until one handshake, discard it, clear the flag, go to IDLE. cmd_ready stays 0 throughout, so late responses are never mis-associated.
- Latency with zero-wait slave (accept cycle 0):
  - Write: AW/W handshake cycle 1, B handshake cycle 2, rsp_valid cycle 3.
  - Read: AR cycle 1, R cycle 2, rsp_valid cycle 3.
- Back-to-back: next command can be accepted the cycle after the rsp handshake.

Test Plan:
- Reset, then write addr 0x4, data 0xDEADBEEF, wstrb 0xF to a zero-wait slave -> awvalid/wvalid high cycle 1, bready cycle 2, rsp_valid cycle 3 with rsp_resp=00, rsp_timeout=0.
- Read 0x4 after the above -> arvalid cycle 1, rsp_rdata=0xDEADBEEF, rsp_resp=00; then read 0x100 (unmapped) -> rsp_resp=10.
- Write with awready held low 3 cycles, wready immediate -> wvalid drops after cycle 1, awvalid held with stable awaddr through cycle 4, exactly one B handshake, rsp_resp=00.
- TIMEOUT_CYCLES=16, slave never asserts bvalid -> rsp_valid with rsp_timeout=1, rsp_resp=10; cmd_ready=0 until a late bvalid injected 40 cycles later is drained; then IDLE.
- rsp_ready held low 10 cycles after read completes -> rsp_valid/rsp_rdata/rsp_resp stable, cmd_ready=0, no AXI activity.
- Assert reset in WR_REQ with awvalid high -> next cycle all valids/readies 0, cmd_ready=1 after reset release.
